// File: rtl/uart_tx_stream_fifo_pkg.sv
// Shared UART definitions: FIFO geometry defaults and interrupt-source indices
// so that the APB status/interrupt registers and the FIFOs agree on bit positions.
package uart_tx_stream_fifo_pkg;

  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_PAYLOAD_W  = 8;

  // Bit positions in the APB interrupt status/enable registers.
  typedef enum logic [1:0] {
    UART_IRQ_TX_LEVEL  = 2'd0,
    UART_IRQ_RX_LEVEL  = 2'd1,
    UART_IRQ_RX_ERROR  = 2'd2,
    UART_IRQ_BREAK     = 2'd3
  } uartIrqSrc_e;

  localparam int UART_IRQ_COUNT = 4;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage for the UART FIFOs: synchronous write, asynchronous read.
module uart_fifo_mem
  import uart_tx_stream_fifo_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int WIDTH = UART_PAYLOAD_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             io_mainClk,
  input  logic             io_wrEn,
  input  logic [AW-1:0]    io_wrAddr,
  input  logic [WIDTH-1:0] io_wrData,
  input  logic [AW-1:0]    io_rdAddr,
  output logic [WIDTH-1:0] io_rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge io_mainClk) begin
    if (io_wrEn) mem[io_wrAddr] <= io_wrData;
  end

  assign io_rdData = mem[io_rdAddr];

endmodule

// File: rtl/uart_tx_stream_fifo.sv
// Transmit FIFO between the APB data register and the UART transmit controller,
// with occupancy/availability status and a below-threshold level interrupt.
module uart_tx_stream_fifo
  import uart_tx_stream_fifo_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int WIDTH = UART_PAYLOAD_W,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             io_mainClk,
  input  logic             resetCtrl_systemResetn,
  input  logic             io_push_valid,
  output logic             io_push_ready,
  input  logic [WIDTH-1:0] io_push_payload,
  output logic             io_pop_valid,
  input  logic             io_pop_ready,
  output logic [WIDTH-1:0] io_pop_payload,
  input  logic             io_flush,
  input  logic [CW-1:0]    io_threshold,
  input  logic             io_interruptEnable,
  output logic [CW-1:0]    io_occupancy,
  output logic [CW-1:0]    io_availability,
  output logic             io_interrupt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_CW = CW'(DEPTH);

  logic [AW:0]   wrPtr;
  logic [AW:0]   rdPtr;
  logic [CW-1:0] occupancy;
  logic          isEmpty;
  logic          isFull;
  logic          clearAll;
  logic          pushFire;
  logic          popFire;

  // Extra wrap bit distinguishes full from empty when the low bits match.
  assign isEmpty = (wrPtr == rdPtr);
  assign isFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

  // Reset behaves exactly like flush; both suppress any handshake this cycle.
  assign clearAll = !resetCtrl_systemResetn || io_flush;
  assign pushFire = io_push_valid && !isFull && !clearAll;
  assign popFire  = io_pop_ready && !isEmpty && !clearAll;

  always_ff @(posedge io_mainClk) begin
    if (clearAll) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else begin
      if (pushFire) wrPtr <= wrPtr + (AW+1)'(1);
      if (popFire)  rdPtr <= rdPtr + (AW+1)'(1);
      case ({pushFire, popFire})
        2'b10:   occupancy <= occupancy + CW'(1);
        2'b01:   occupancy <= occupancy - CW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .io_mainClk (io_mainClk),
    .io_wrEn    (pushFire),
    .io_wrAddr  (wrPtr[AW-1:0]),
    .io_wrData  (io_push_payload),
    .io_rdAddr  (rdPtr[AW-1:0]),
    .io_rdData  (io_pop_payload)
  );

  assign io_push_ready   = !isFull;
  assign io_pop_valid    = !isEmpty;
  assign io_occupancy    = occupancy;
  assign io_availability = DEPTH_CW - occupancy;
  assign io_interrupt    = io_interruptEnable && (occupancy < io_threshold);

endmodule
